// File: rtl/jtgng_ps2_pkg.sv
// rtl/jtgng_ps2_pkg.sv - shared constants and types for the PS/2 keyboard event path
package jtgng_ps2_pkg;

    localparam logic [7:0] SC_00 = 8'h00;
    localparam logic [7:0] SC_AA = 8'hAA;
    localparam logic [7:0] SC_E0 = 8'hE0;
    localparam logic [7:0] SC_E1 = 8'hE1;
    localparam logic [7:0] SC_EE = 8'hEE;
    localparam logic [7:0] SC_F0 = 8'hF0;
    localparam logic [7:0] SC_FA = 8'hFA;
    localparam logic [7:0] SC_FE = 8'hFE;
    localparam logic [7:0] SC_FF = 8'hFF;

    localparam int FRAME_LEN = 11;

    localparam int KEY_TOGGLE  = 10;
    localparam int KEY_PRESSED = 9;
    localparam int KEY_EXT     = 8;

    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_SHIFT = 2'd1,
        RX_STOP  = 2'd2
    } rx_state_t;

    // Device housekeeping bytes (BAT, ack, echo, resend, overrun) carry no key
    function automatic logic is_status_byte(input logic [7:0] b);
        return (b == SC_00) || (b == SC_AA) || (b == SC_EE) ||
               (b == SC_FA) || (b == SC_FE) || (b == SC_FF);
    endfunction

endpackage

// File: rtl/jtgng_ps2_rx.sv
// rtl/jtgng_ps2_rx.sv - PS/2 line synchronizer and 11-bit frame deserializer
module jtgng_ps2_rx
    import jtgng_ps2_pkg::*;
#(
    parameter int CLK_SPEED  = 48,
    parameter int TIMEOUT_US = 200
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic       byte_valid,
    output logic [7:0] byte_data,
    output logic       frame_err
);

    localparam int TMO_CYCLES = CLK_SPEED * TIMEOUT_US;
    localparam int TW         = $clog2(TMO_CYCLES + 1);

    logic [1:0]    clk_sync;
    logic [1:0]    data_sync;
    logic          clk_prev;
    logic          fall;
    logic          bit_in;
    logic          tmo;

    rx_state_t     state, state_n;
    logic [3:0]    cnt, cnt_n;
    logic [8:0]    shift, shift_n;
    logic [TW-1:0] timer, timer_n;
    logic          valid_n;
    logic          err_n;

    assign fall   = clk_prev & ~clk_sync[1];
    assign bit_in = data_sync[1];
    assign tmo    = (timer == TW'(TMO_CYCLES));

    always_ff @(posedge clk) begin
        if (rst) begin
            clk_sync   <= 2'b11;
            data_sync  <= 2'b11;
            clk_prev   <= 1'b1;
            state      <= RX_IDLE;
            cnt        <= '0;
            shift      <= '0;
            timer      <= '0;
            byte_valid <= 1'b0;
            byte_data  <= '0;
            frame_err  <= 1'b0;
        end else begin
            clk_sync   <= {clk_sync[0], ps2_clk};
            data_sync  <= {data_sync[0], ps2_data};
            clk_prev   <= clk_sync[1];
            state      <= state_n;
            cnt        <= cnt_n;
            shift      <= shift_n;
            timer      <= timer_n;
            byte_valid <= valid_n;
            frame_err  <= err_n;
            if (valid_n) byte_data <= shift[7:0];
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        shift_n = shift;
        valid_n = 1'b0;
        err_n   = 1'b0;
        // Timer only runs inside a frame; any edge restarts the gap measurement
        if (fall || state == RX_IDLE) timer_n = '0;
        else                          timer_n = timer + 1'b1;

        case (state)
            RX_IDLE: begin
                if (fall) begin
                    if (!bit_in) begin
                        state_n = RX_SHIFT;
                        cnt_n   = 4'd1;
                    end else begin
                        err_n = 1'b1;
                    end
                end
            end
            RX_SHIFT: begin
                if (fall) begin
                    shift_n = {bit_in, shift[8:1]};
                    cnt_n   = cnt + 4'd1;
                    if (cnt == 4'(FRAME_LEN - 2)) state_n = RX_STOP;
                end else if (tmo) begin
                    err_n   = 1'b1;
                    state_n = RX_IDLE;
                end
            end
            RX_STOP: begin
                if (fall) begin
                    // shift holds 8 data bits plus parity: odd overall weight is good
                    if (bit_in && (^shift)) valid_n = 1'b1;
                    else                    err_n   = 1'b1;
                    state_n = RX_IDLE;
                    cnt_n   = '0;
                end else if (tmo) begin
                    err_n   = 1'b1;
                    state_n = RX_IDLE;
                end
            end
            default: state_n = RX_IDLE;
        endcase

        if (state_n == RX_IDLE) cnt_n = '0;
    end

endmodule

// File: rtl/jtgng_ps2_event.sv
// rtl/jtgng_ps2_event.sv - scan-code set 2 prefix decoder producing the toggle-flagged ps2_key word
module jtgng_ps2_event
    import jtgng_ps2_pkg::*;
#(
    parameter int CLK_SPEED  = 48,
    parameter int TIMEOUT_US = 200
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ps2_clk,
    input  logic        ps2_data,
    output logic [10:0] ps2_key,
    output logic        frame_err
);

    logic       byte_valid;
    logic [7:0] byte_data;
    logic       ext;
    logic       brk;
    logic [2:0] skip;

    jtgng_ps2_rx #(
        .CLK_SPEED  (CLK_SPEED),
        .TIMEOUT_US (TIMEOUT_US)
    ) u_rx (
        .clk        (clk),
        .rst        (rst),
        .ps2_clk    (ps2_clk),
        .ps2_data   (ps2_data),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .frame_err  (frame_err)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            ps2_key <= '0;
            ext     <= 1'b0;
            brk     <= 1'b0;
            skip    <= '0;
        end else if (frame_err) begin
            ext  <= 1'b0;
            brk  <= 1'b0;
            skip <= '0;
        end else if (byte_valid) begin
            if (skip != 3'd0) begin
                // Pause key sends an 8-byte E1 sequence with no break form
                skip <= skip - 3'd1;
            end else if (byte_data == SC_E1) begin
                skip <= 3'd7;
                ext  <= 1'b0;
                brk  <= 1'b0;
            end else if (byte_data == SC_E0) begin
                ext <= 1'b1;
            end else if (byte_data == SC_F0) begin
                brk <= 1'b1;
            end else if (!ext && !brk && is_status_byte(byte_data)) begin
                ext <= ext;
            end else begin
                ps2_key[KEY_TOGGLE]  <= ~ps2_key[KEY_TOGGLE];
                ps2_key[KEY_PRESSED] <= ~brk;
                ps2_key[KEY_EXT]     <= ext;
                ps2_key[7:0]         <= byte_data;
                ext <= 1'b0;
                brk <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_jtgng_ps2_event.sv
// tb/tb_jtgng_ps2_event.sv - scoreboard bench for jtgng_ps2_event
module tb_jtgng_ps2_event;

    localparam int HALF = 20;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ps2_clk = 1'b1;
    logic        ps2_data = 1'b1;
    logic [10:0] ps2_key;
    logic        frame_err;

    typedef struct {
        logic        is_err;
        logic [10:0] key;
    } exp_t;

    exp_t        sb[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    logic [10:0] key_prev = '0;
    logic        err_prev = 1'b0;
    time         t_fall = 0;

    always #5 clk = ~clk;

    jtgng_ps2_event #(.CLK_SPEED(48), .TIMEOUT_US(200)) dut (
        .clk       (clk),
        .rst       (rst),
        .ps2_clk   (ps2_clk),
        .ps2_data  (ps2_data),
        .ps2_key   (ps2_key),
        .frame_err (frame_err)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b);
        ps2_data = b;
        wait_cyc(HALF);
        ps2_clk = 1'b0;
        t_fall  = $time;
        wait_cyc(HALF);
        ps2_clk = 1'b1;
    endtask

    function automatic logic [10:0] frame_bits(input logic [7:0] b, input logic bad_par, input logic bad_stop);
        logic par;
        par = ~(^b) ^ bad_par;
        return {~bad_stop, par, b, 1'b0};
    endfunction

    task automatic send_byte(input logic [7:0] b, input logic bad_par = 1'b0, input logic bad_stop = 1'b0);
        logic [10:0] f;
        f = frame_bits(b, bad_par, bad_stop);
        for (int i = 0; i < 11; i++) send_bit(f[i]);
        ps2_data = 1'b1;
        wait_cyc(HALF);
    endtask

    task automatic send_partial(input logic [7:0] b, input int nbits);
        logic [10:0] f;
        f = frame_bits(b, 1'b0, 1'b0);
        for (int i = 0; i < nbits; i++) send_bit(f[i]);
        ps2_data = 1'b1;
    endtask

    task automatic expect_key(input logic [10:0] k);
        exp_t e;
        e.is_err = 1'b0;
        e.key    = k;
        sb.push_back(e);
    endtask

    task automatic expect_err();
        exp_t e;
        e.is_err = 1'b1;
        e.key    = '0;
        sb.push_back(e);
    endtask

    // Monitor: pops one expectation per observed error pulse or ps2_key change
    always @(negedge clk) begin
        exp_t e;
        if (frame_err) begin
            if (err_prev) check("frame_err_width", 32'd2, 32'd1);
            if (sb.size() == 0) begin
                check("unexpected_frame_err", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                check("frame_err_expected", 32'(frame_err), 32'(e.is_err));
            end
        end
        if (ps2_key !== key_prev) begin
            if (sb.size() == 0) begin
                check("unexpected_key", 32'(ps2_key), 32'(key_prev));
            end else begin
                e = sb.pop_front();
                check("key_is_event", 32'(e.is_err), 32'd0);
                check("ps2_key", 32'(ps2_key), 32'(e.key));
            end
        end
        key_prev = ps2_key;
        err_prev = frame_err;
    end

    initial begin
        logic [10:0] f;
        int          n;
        int          gap;

        wait_cyc(4);
        check("reset_key", 32'(ps2_key), 32'h000);
        check("reset_err", 32'(frame_err), 32'd0);
        rst = 1'b0;
        wait_cyc(4);

        // First make with latency measurement from stop-bit falling edge
        expect_key(11'h61C);
        f = frame_bits(8'h1C, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) send_bit(f[i]);
        ps2_data = 1'b1;
        wait_cyc(HALF);
        ps2_clk = 1'b0;
        n = 0;
        while (ps2_key == 11'h000 && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("latency", 32'(n), 32'd4);
        wait_cyc(HALF);
        ps2_clk = 1'b1;
        wait_cyc(HALF);

        expect_key(11'h01C);
        send_byte(8'hF0); send_byte(8'h1C);

        expect_key(11'h775);
        send_byte(8'hE0); send_byte(8'h75);
        expect_key(11'h175);
        send_byte(8'hE0); send_byte(8'hF0); send_byte(8'h75);

        // Parity error discards the pending F0
        expect_err();
        send_byte(8'hF0); send_byte(8'h29, 1'b1);
        expect_key(11'h629);
        send_byte(8'h29);

        // Inter-bit timeout
        expect_err();
        send_partial(8'h55, 5);
        n = 0;
        while (!frame_err && n < 12000) begin
            @(negedge clk);
            n++;
        end
        gap = int'(($time - t_fall) / 10);
        check("timeout_seen", 32'(frame_err), 32'd1);
        check("timeout_gap_lo", 32'(gap >= 9598), 32'd1);
        check("timeout_gap_hi", 32'(gap <= 9606), 32'd1);
        wait_cyc(HALF);
        expect_key(11'h214);
        send_byte(8'h14);

        // Pause sequence yields nothing, following key decodes
        send_byte(8'hE1); send_byte(8'h14); send_byte(8'h77); send_byte(8'hE1);
        send_byte(8'hF0); send_byte(8'h14); send_byte(8'hF0); send_byte(8'h77);
        expect_key(11'h605);
        send_byte(8'h05);

        expect_key(11'h36B);
        send_byte(8'hE0); send_byte(8'hE0); send_byte(8'h6B);

        // Status bytes, bad start bit, bad stop bit
        send_byte(8'hAA); send_byte(8'hFA);
        expect_err();
        send_bit(1'b1);
        wait_cyc(HALF);
        expect_err();
        send_byte(8'h33, 1'b0, 1'b1);

        // Reset mid-frame
        expect_key(11'h000);
        send_partial(8'h1C, 6);
        rst = 1'b1;
        wait_cyc(3);
        rst = 1'b0;
        wait_cyc(HALF);
        expect_key(11'h61C);
        send_byte(8'h1C);

        n = 0;
        while (sb.size() != 0 && n < 200) begin
            wait_cyc(1);
            n++;
        end
        wait_cyc(20);
        check("scoreboard_drained", 32'(sb.size()), 32'd0);
        check("final_key", 32'(ps2_key), 32'h61C);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
